// File: rtl/wb_arbiter.sv
// wb_arbiter: fixed-priority (mem > alu > mul) write-back collector feeding one regfile write port.
// Optional macro WB_BYPASS_EN lets an accepted result skip the empty FIFO straight onto the port.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
module wb_arbiter #(
  parameter int QDEPTH   = 4,
  parameter int REG_ADDR = `REG_ADDR,
  parameter int REG_SIZE = `REG_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic [REG_ADDR-1:0]       mem_rd,
  input  logic [REG_SIZE-1:0]       mem_data,
  output logic                      mem_ready,
  input  logic                      alu_valid,
  input  logic [REG_ADDR-1:0]       alu_rd,
  input  logic [REG_SIZE-1:0]       alu_data,
  output logic                      alu_ready,
  input  logic                      mul_valid,
  input  logic [REG_ADDR-1:0]       mul_rd,
  input  logic [REG_SIZE-1:0]       mul_data,
  output logic                      mul_ready,
  input  logic [REG_ADDR-1:0]       rreg1,
  input  logic [REG_ADDR-1:0]       rreg2,
  output logic                      pend1,
  output logic                      pend2,
  output logic                      regwrite,
  output logic [REG_ADDR-1:0]       wreg,
  output logic [REG_SIZE-1:0]       wdata,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int PW = $clog2(QDEPTH);
  logic [REG_ADDR-1:0] rd_q [QDEPTH];
  logic [REG_SIZE-1:0] data_q [QDEPTH];
  logic [PW-1:0] wp_q, rp_q, off;
  logic [PW:0] cnt_q, cnt_d;
  logic regwrite_q;
  logic [REG_ADDR-1:0] wreg_q, acc_rd;
  logic [REG_SIZE-1:0] wdata_q, acc_data;
  logic pop, room, live, byp, push, hit1, hit2;
  assign pop       = cnt_q != '0;
  assign room      = (cnt_q < (PW+1)'(QDEPTH)) | pop;
  assign mem_ready = !rst & mem_valid & room;
  assign alu_ready = !rst & alu_valid & !mem_valid & room;
  assign mul_ready = !rst & mul_valid & !mem_valid & !alu_valid & room;
  assign acc_rd    = mem_ready ? mem_rd : alu_ready ? alu_rd : mul_rd;
  assign acc_data  = mem_ready ? mem_data : alu_ready ? alu_data : mul_data;
  // rd==0 transfers are acknowledged but dropped
  assign live      = (mem_ready | alu_ready | mul_ready) & (acc_rd != '0);
`ifdef WB_BYPASS_EN
  assign byp       = live & !pop;
`else
  assign byp       = 1'b0;
`endif
  assign push      = live & !byp;
  assign cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int j = 0; j < QDEPTH; j++) begin
      off = PW'(j) - rp_q;
      if ({1'b0, off} < cnt_q) begin
        hit1 = hit1 | (rd_q[j] == rreg1);
        hit2 = hit2 | (rd_q[j] == rreg2);
      end
    end
  end
  assign pend1 = (rreg1 != '0) & (hit1 | (regwrite_q & (wreg_q == rreg1)));
  assign pend2 = (rreg2 != '0) & (hit2 | (regwrite_q & (wreg_q == rreg2)));
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (push) begin
        rd_q[wp_q]   <= acc_rd;
        data_q[wp_q] <= acc_data;
        wp_q         <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q      <= cnt_d;
      regwrite_q <= pop | byp;
      if (pop) begin
        wreg_q  <= rd_q[rp_q];
        wdata_q <= data_q[rp_q];
      end else if (byp) begin
        wreg_q  <= acc_rd;
        wdata_q <= acc_data;
      end
    end
  end
  assign regwrite = regwrite_q;
  assign wreg     = wreg_q;
  assign wdata    = wdata_q;
  assign count    = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors, directed sequences and random traffic against a queue-based model.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
module tb_wb_arbiter;
  localparam int QD = 4;
  localparam int RA = `REG_ADDR;
  localparam int RS = `REG_SIZE;
  logic clk = 1'b0;
  logic rst;
  logic mem_valid, alu_valid, mul_valid;
  logic [RA-1:0] mem_rd, alu_rd, mul_rd, rreg1, rreg2, wreg;
  logic [RS-1:0] mem_data, alu_data, mul_data, wdata;
  logic mem_ready, alu_ready, mul_ready, pend1, pend2, regwrite;
  logic [$clog2(QD):0] count;
  wb_arbiter #(.QDEPTH(QD), .REG_ADDR(RA), .REG_SIZE(RS)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data), .mul_ready(mul_ready),
    .rreg1(rreg1), .rreg2(rreg2), .pend1(pend1), .pend2(pend2),
    .regwrite(regwrite), .wreg(wreg), .wdata(wdata), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [RA-1:0] rd;
    logic [RS-1:0] data;
  } ent_t;
  typedef struct {
    logic r, mv, av, uv, emr, ear, eur;
  } vec_t;
  ent_t q[$];
  int dlog[$];
  logic m_we;
  logic [RA-1:0] m_reg;
  logic [RS-1:0] m_data;
  logic em, ea, eu;
  int checks = 0;
  int errors = 0;
  int maxcnt = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic mpend(input logic [RA-1:0] rr);
    if (rr == 0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rr) return 1'b1;
    return m_we && m_reg == rr;
  endfunction
  task automatic idle();
    mem_valid = 0; alu_valid = 0; mul_valid = 0;
  endtask
  task automatic step();
    logic popped, room;
    ent_t e;
    @(negedge clk);
    room = q.size() < QD || q.size() > 0;
    em = !rst && mem_valid && room;
    ea = !rst && alu_valid && !mem_valid && room;
    eu = !rst && mul_valid && !mem_valid && !alu_valid && room;
    chk("mem_ready", mem_ready, em);
    chk("alu_ready", alu_ready, ea);
    chk("mul_ready", mul_ready, eu);
    chk("pend1", pend1, mpend(rreg1));
    chk("pend2", pend2, mpend(rreg2));
    chk("count", count, q.size());
    chk("regwrite", regwrite, m_we);
    chk("wreg", wreg, m_reg);
    chk("wdata", wdata, m_data);
    if (int'(count) > maxcnt) maxcnt = int'(count);
    if (regwrite) dlog.push_back(int'(wreg));
    @(posedge clk);
    if (rst) begin
      q.delete(); m_we = 0; m_reg = 0; m_data = 0;
    end else begin
      popped = q.size() > 0;
      m_we = popped;
      if (popped) begin
        m_reg = q[0].rd; m_data = q[0].data; void'(q.pop_front());
      end
      if (em || ea || eu) begin
        e.rd   = em ? mem_rd : ea ? alu_rd : mul_rd;
        e.data = em ? mem_data : ea ? alu_data : mul_data;
        if (e.rd != 0) begin
`ifdef WB_BYPASS_EN
          if (!popped) begin
            m_we = 1; m_reg = e.rd; m_data = e.data;
          end else q.push_back(e);
`else
          q.push_back(e);
`endif
        end
      end
    end
    #1;
  endtask
  vec_t tv[10];
  initial begin
    rst = 1; idle();
    mem_rd = 0; alu_rd = 0; mul_rd = 0; mem_data = 0; alu_data = 0; mul_data = 0;
    rreg1 = 0; rreg2 = 0;
    m_we = 0; m_reg = 0; m_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tv[0] = '{0,0,0,0, 0,0,0};
    tv[1] = '{0,1,0,0, 1,0,0};
    tv[2] = '{0,0,1,0, 0,1,0};
    tv[3] = '{0,0,0,1, 0,0,1};
    tv[4] = '{0,1,1,0, 1,0,0};
    tv[5] = '{0,0,1,1, 0,1,0};
    tv[6] = '{0,1,0,1, 1,0,0};
    tv[7] = '{0,1,1,1, 1,0,0};
    tv[8] = '{1,1,1,1, 0,0,0};
    tv[9] = '{1,0,1,0, 0,0,0};
    for (int i = 0; i < 10; i++) begin
      rst = tv[i].r; mem_valid = tv[i].mv; alu_valid = tv[i].av; mul_valid = tv[i].uv;
      #1;
      chk("tv_mem_ready", mem_ready, tv[i].emr);
      chk("tv_alu_ready", alu_ready, tv[i].ear);
      chk("tv_mul_ready", mul_ready, tv[i].eur);
    end
    rst = 0; idle();
    #1 chk("reset_count", count, 0);
    chk("reset_regwrite", regwrite, 0);
    // single ALU write, watch pend1 until it leaves the port
    rreg1 = 5; rreg2 = 4;
    alu_valid = 1; alu_rd = 5; alu_data = 'h1234;
    dlog.delete();
    step();
    idle();
    repeat (4) step();
    chk("single_nwrites", dlog.size(), 1);
    if (dlog.size() == 1) chk("single_wreg", dlog[0], 5);
    chk("single_pend_clear", pend1, 0);
    // all three sources at once
    mem_valid = 1; mem_rd = 3; mem_data = 'hA;
    alu_valid = 1; alu_rd = 4; alu_data = 'hB;
    mul_valid = 1; mul_rd = 6; mul_data = 'hC;
    dlog.delete();
    #1 chk("simul_alu_blocked", alu_ready, 0);
    for (int c = 0; c < 8; c++) begin
      step();
      if (em) mem_valid = 0;
      if (ea) alu_valid = 0;
      if (eu) mul_valid = 0;
    end
    chk("simul_nwrites", dlog.size(), 3);
    if (dlog.size() == 3) begin
      chk("simul_w0", dlog[0], 3); chk("simul_w1", dlog[1], 4); chk("simul_w2", dlog[2], 6);
    end
    // back-to-back stream of ten ALU results
    dlog.delete(); maxcnt = 0;
    alu_valid = 1;
    for (int i = 1; i <= 10; i++) begin
      alu_rd = RA'(i); alu_data = RS'(i * 17);
      rreg2 = RA'(i);
      step();
    end
    idle();
    repeat (4) step();
    chk("stream_nwrites", dlog.size(), 10);
    for (int i = 0; i < dlog.size() && i < 10; i++) chk("stream_order", dlog[i], i + 1);
    chk("stream_maxcnt_ok", maxcnt <= QD, 1);
    // register zero is acknowledged but dropped
    dlog.delete(); rreg1 = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 'hFFFF;
    step();
    idle();
    repeat (3) step();
    chk("rd0_nwrites", dlog.size(), 0);
    chk("rd0_pend1", pend1, 0);
    // reset in the middle of traffic
    mem_valid = 1; mem_rd = 7; mem_data = 'h77;
    alu_valid = 1; alu_rd = 8; alu_data = 'h88;
    step();
    rst = 1;
    step();
    rst = 0; idle();
    dlog.delete();
    #1 chk("midrst_count", count, 0);
    chk("midrst_regwrite", regwrite, 0);
    chk("midrst_wreg", wreg, 0);
    chk("midrst_wdata", wdata, 0);
    repeat (3) step();
    chk("midrst_nwrites", dlog.size(), 0);
    // random traffic: producers hold their request until accepted
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!mem_valid && $urandom_range(0, 2) == 0) begin
        mem_valid = 1; mem_rd = RA'($urandom_range(0, 7)); mem_data = RS'($urandom);
      end
      if (!alu_valid && $urandom_range(0, 1) == 0) begin
        alu_valid = 1; alu_rd = RA'($urandom_range(0, 7)); alu_data = RS'($urandom);
      end
      if (!mul_valid && $urandom_range(0, 2) == 0) begin
        mul_valid = 1; mul_rd = RA'($urandom_range(0, 7)); mul_data = RS'($urandom);
      end
      rreg1 = RA'($urandom_range(0, 7));
      rreg2 = RA'($urandom_range(0, 7));
      step();
      if (em) mem_valid = 0;
      if (ea) alu_valid = 0;
      if (eu) mul_valid = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
